// File: rtl/wb_retire_unit.sv
// Write-back and retire stage: one-deep stage register, register-file write port,
// trap/halt detection, retired-instruction counter and a trace FIFO for the consumer.
module wb_retire_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TRACE_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [XLEN-1:0]                i_inst,
  input  logic [XLEN-1:0]                i_pc,
  input  logic [XLEN-1:0]                i_next_pc,
  input  logic [4:0]                     i_rd,
  input  logic                           i_reg_write,
  input  logic [2:0]                     i_wb_sel,
  input  logic [XLEN-1:0]                i_alu_result,
  input  logic [XLEN-1:0]                i_load_data,
  input  logic [XLEN-1:0]                i_pc_plus_4,
  input  logic [XLEN-1:0]                i_imm,
  input  logic                           i_unaligned_pc,
  input  logic                           i_unaligned_mem,
  output logic [4:0]                     o_wb_rd,
  output logic [XLEN-1:0]                o_wb_rd_data,
  output logic                           o_wb_reg_write,
  output logic                           o_trace_valid,
  input  logic                           i_trace_ready,
  output logic [XLEN-1:0]                o_trace_pc,
  output logic [XLEN-1:0]                o_trace_next_pc,
  output logic [XLEN-1:0]                o_trace_inst,
  output logic [XLEN-1:0]                o_trace_rd_wdata,
  output logic [4:0]                     o_trace_rd,
  output logic                           o_trace_trap,
  output logic                           o_trace_halt,
  output logic [$clog2(TRACE_DEPTH):0]   o_trace_level,
  output logic                           o_halted,
  output logic [63:0]                    o_instret
);

  localparam int unsigned AW = $clog2(TRACE_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t state, state_n;

  logic            r_valid;
  logic [XLEN-1:0] r_inst, r_pc, r_next_pc;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic [2:0]      r_wb_sel;
  logic [XLEN-1:0] r_alu_result, r_load_data, r_pc_plus_4, r_imm;
  logic            r_unaligned_pc, r_unaligned_mem;

  logic            r_illegal, r_trap, r_halt;
  logic [XLEN-1:0] rd_data;
  logic [4:0]      rec_rd;
  logic [XLEN-1:0] rec_wdata;

  logic [LW-1:0]   fifo_count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            have_head, pop, retire, accept;

  logic [XLEN-1:0] f_pc     [TRACE_DEPTH];
  logic [XLEN-1:0] f_next_pc[TRACE_DEPTH];
  logic [XLEN-1:0] f_inst   [TRACE_DEPTH];
  logic [XLEN-1:0] f_wdata  [TRACE_DEPTH];
  logic [4:0]      f_rd     [TRACE_DEPTH];
  logic            f_trap   [TRACE_DEPTH];
  logic            f_halt   [TRACE_DEPTH];

  assign have_head = (fifo_count != '0);
  assign pop       = have_head && i_trace_ready;
  // A full FIFO still accepts a retire when the head is popped in the same cycle.
  assign retire    = r_valid && ((fifo_count != LW'(TRACE_DEPTH)) || pop);
  assign o_ready   = !i_rst && (state == RUN) && (!r_valid || retire) && !(retire && r_halt);
  assign accept    = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid         <= 1'b0;
      r_inst          <= '0;
      r_pc            <= '0;
      r_next_pc       <= '0;
      r_rd            <= '0;
      r_reg_write     <= 1'b0;
      r_wb_sel        <= '0;
      r_alu_result    <= '0;
      r_load_data     <= '0;
      r_pc_plus_4     <= '0;
      r_imm           <= '0;
      r_unaligned_pc  <= 1'b0;
      r_unaligned_mem <= 1'b0;
    end else if (accept) begin
      r_valid         <= 1'b1;
      r_inst          <= i_inst;
      r_pc            <= i_pc;
      r_next_pc       <= i_next_pc;
      r_rd            <= i_rd;
      r_reg_write     <= i_reg_write;
      r_wb_sel        <= i_wb_sel;
      r_alu_result    <= i_alu_result;
      r_load_data     <= i_load_data;
      r_pc_plus_4     <= i_pc_plus_4;
      r_imm           <= i_imm;
      r_unaligned_pc  <= i_unaligned_pc;
      r_unaligned_mem <= i_unaligned_mem;
    end else if (retire) begin
      r_valid         <= 1'b0;
    end
  end

  always_comb begin
    case (r_inst[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011: r_illegal = 1'b0;
      default:                                                    r_illegal = 1'b1;
    endcase
  end

  assign r_trap = r_illegal | r_unaligned_pc | r_unaligned_mem;
  assign r_halt = r_trap | (r_inst == XLEN'(32'h0010_0073));

  always_comb begin
    case (r_wb_sel)
      3'd1:    rd_data = r_load_data;
      3'd2:    rd_data = r_pc_plus_4;
      3'd3:    rd_data = r_imm;
      3'd4:    rd_data = r_pc + r_imm;
      default: rd_data = r_alu_result;
    endcase
  end

  assign rec_rd    = (r_reg_write && !r_trap) ? r_rd : 5'd0;
  assign rec_wdata = (rec_rd != 5'd0) ? rd_data : '0;

  assign o_wb_rd        = r_rd;
  assign o_wb_rd_data   = rd_data;
  assign o_wb_reg_write = retire && r_reg_write && (r_rd != 5'd0) && !r_trap;

  always_ff @(posedge i_clk) begin
    if (retire) begin
      f_pc[wr_ptr]      <= r_pc;
      f_next_pc[wr_ptr] <= r_next_pc;
      f_inst[wr_ptr]    <= r_inst;
      f_wdata[wr_ptr]   <= rec_wdata;
      f_rd[wr_ptr]      <= rec_rd;
      f_trap[wr_ptr]    <= r_trap;
      f_halt[wr_ptr]    <= r_halt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      o_instret  <= '0;
    end else begin
      if (retire) begin
        wr_ptr    <= wr_ptr + AW'(1);
        o_instret <= o_instret + 64'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (retire && !pop)      fifo_count <= fifo_count + LW'(1);
      else if (!retire && pop) fifo_count <= fifo_count - LW'(1);
    end
  end

  // Head fields are masked rather than cleared so the storage needs no reset.
  assign o_trace_valid    = have_head;
  assign o_trace_level    = fifo_count;
  assign o_trace_pc       = have_head ? f_pc[rd_ptr]      : '0;
  assign o_trace_next_pc  = have_head ? f_next_pc[rd_ptr] : '0;
  assign o_trace_inst     = have_head ? f_inst[rd_ptr]    : '0;
  assign o_trace_rd_wdata = have_head ? f_wdata[rd_ptr]   : '0;
  assign o_trace_rd       = have_head ? f_rd[rd_ptr]      : 5'd0;
  assign o_trace_trap     = have_head && f_trap[rd_ptr];
  assign o_trace_halt     = have_head && f_halt[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (retire && r_halt) state_n = HALTED;
      HALTED:  state_n = HALTED;
      default: state_n = RUN;
    endcase
  end

  assign o_halted = (state == HALTED);

endmodule

// File: tb/tb_wb_retire_unit.sv
// Bench for wb_retire_unit: directed scenarios plus randomized traffic, all checked
// continuously against a queue-based behavioural model of the stage and trace FIFO.
module tb_wb_retire_unit;

  localparam int DEPTH = 4;

  logic        i_clk, i_rst, i_valid, o_ready;
  logic [31:0] i_inst, i_pc, i_next_pc;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic [2:0]  i_wb_sel;
  logic [31:0] i_alu_result, i_load_data, i_pc_plus_4, i_imm;
  logic        i_unaligned_pc, i_unaligned_mem;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_rd_data;
  logic        o_wb_reg_write, o_trace_valid, i_trace_ready;
  logic [31:0] o_trace_pc, o_trace_next_pc, o_trace_inst, o_trace_rd_wdata;
  logic [4:0]  o_trace_rd;
  logic        o_trace_trap, o_trace_halt;
  logic [2:0]  o_trace_level;
  logic        o_halted;
  logic [63:0] o_instret;

  wb_retire_unit #(.XLEN(32), .TRACE_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_inst(i_inst), .i_pc(i_pc), .i_next_pc(i_next_pc), .i_rd(i_rd),
    .i_reg_write(i_reg_write), .i_wb_sel(i_wb_sel), .i_alu_result(i_alu_result),
    .i_load_data(i_load_data), .i_pc_plus_4(i_pc_plus_4), .i_imm(i_imm),
    .i_unaligned_pc(i_unaligned_pc), .i_unaligned_mem(i_unaligned_mem),
    .o_wb_rd(o_wb_rd), .o_wb_rd_data(o_wb_rd_data), .o_wb_reg_write(o_wb_reg_write),
    .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
    .o_trace_pc(o_trace_pc), .o_trace_next_pc(o_trace_next_pc),
    .o_trace_inst(o_trace_inst), .o_trace_rd_wdata(o_trace_rd_wdata),
    .o_trace_rd(o_trace_rd), .o_trace_trap(o_trace_trap), .o_trace_halt(o_trace_halt),
    .o_trace_level(o_trace_level), .o_halted(o_halted), .o_instret(o_instret)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  typedef struct packed {
    logic [31:0] pc, npc, inst, wdata;
    logic [4:0]  rd;
    logic        trap, halt, wr;
    logic [4:0]  wrd;
    logic [31:0] wdat;
  } rec_t;

  rec_t        m_r[$];
  rec_t        m_fifo[$];
  bit          m_halted;
  logic [63:0] m_instret;
  logic [6:0]  legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

  // Expected record for whatever is currently on the inputs.
  function automatic rec_t make_rec();
    rec_t r;
    logic [31:0] d;
    logic legal;
    legal = i_inst[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};
    case (i_wb_sel)
      3'd1:    d = i_load_data;
      3'd2:    d = i_pc_plus_4;
      3'd3:    d = i_imm;
      3'd4:    d = i_pc + i_imm;
      default: d = i_alu_result;
    endcase
    r.pc    = i_pc;
    r.npc   = i_next_pc;
    r.inst  = i_inst;
    r.trap  = !legal || i_unaligned_pc || i_unaligned_mem;
    r.halt  = r.trap || (i_inst == 32'h0010_0073);
    r.rd    = (i_reg_write && !r.trap) ? i_rd : 5'd0;
    r.wdata = (r.rd != 5'd0) ? d : 32'd0;
    r.wr    = i_reg_write && (i_rd != 5'd0) && !r.trap;
    r.wrd   = i_rd;
    r.wdat  = d;
    return r;
  endfunction

  always @(negedge i_clk) begin : monitor
    bit pop, ret, rdy;
    logic [134:0] exp_head, act_head;
    if (mon_en) begin
      if (i_rst) begin
        checks++;
        if (o_ready !== 1'b0) begin
          failures++;
          $display("FAIL mon_ready_in_reset: got %b expected 0", o_ready);
        end
        m_r.delete();
        m_fifo.delete();
        m_halted  = 0;
        m_instret = '0;
      end else begin
        pop = (m_fifo.size() > 0) && i_trace_ready;
        ret = (m_r.size() > 0) && ((m_fifo.size() < DEPTH) || pop);
        rdy = !m_halted && ((m_r.size() == 0) || ret) && !(ret && m_r[0].halt);
        exp_head = '0;
        if (m_fifo.size() > 0)
          exp_head = {m_fifo[0].pc, m_fifo[0].npc, m_fifo[0].inst, m_fifo[0].rd,
                      m_fifo[0].wdata, m_fifo[0].trap, m_fifo[0].halt};
        act_head = {o_trace_pc, o_trace_next_pc, o_trace_inst, o_trace_rd,
                    o_trace_rd_wdata, o_trace_trap, o_trace_halt};

        checks++;
        if (o_ready !== rdy) begin
          failures++;
          $display("FAIL mon_ready: got %b expected %b at %0t", o_ready, rdy, $time);
        end
        checks++;
        if ({o_trace_valid, o_trace_level} !== {m_fifo.size() > 0, 3'(m_fifo.size())}) begin
          failures++;
          $display("FAIL mon_level: got valid=%b level=%0d expected level=%0d at %0t",
                   o_trace_valid, o_trace_level, m_fifo.size(), $time);
        end
        checks++;
        if (act_head !== exp_head) begin
          failures++;
          $display("FAIL mon_head: got %h expected %h at %0t", act_head, exp_head, $time);
        end
        checks++;
        if ({o_halted, o_instret} !== {m_halted, m_instret}) begin
          failures++;
          $display("FAIL mon_halt_instret: got %b/%0d expected %b/%0d at %0t",
                   o_halted, o_instret, m_halted, m_instret, $time);
        end
        checks++;
        if (o_wb_reg_write !== (ret && m_r[0].wr)) begin
          failures++;
          $display("FAIL mon_wb_we: got %b expected %b at %0t", o_wb_reg_write,
                   ret && m_r[0].wr, $time);
        end
        if (ret && m_r[0].wr) begin
          checks++;
          if ({o_wb_rd, o_wb_rd_data} !== {m_r[0].wrd, m_r[0].wdat}) begin
            failures++;
            $display("FAIL mon_wb_data: got x%0d=%h expected x%0d=%h at %0t",
                     o_wb_rd, o_wb_rd_data, m_r[0].wrd, m_r[0].wdat, $time);
          end
        end

        if (pop) void'(m_fifo.pop_front());
        if (ret) begin
          m_fifo.push_back(m_r[0]);
          m_instret = m_instret + 64'd1;
          if (m_r[0].halt) m_halted = 1;
          void'(m_r.pop_front());
        end
        if (i_valid && rdy) m_r.push_back(make_rec());
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    tick();
    i_rst   = 1'b0;
  endtask

  task automatic set_inst(input logic [31:0] inst, input logic [31:0] pc, input logic [4:0] rd,
                          input logic rw, input logic [2:0] sel, input logic [31:0] alu,
                          input logic [31:0] imm);
    i_valid         = 1'b1;
    i_inst          = inst;
    i_pc            = pc;
    i_next_pc       = pc + 32'd4;
    i_pc_plus_4     = pc + 32'd4;
    i_rd            = rd;
    i_reg_write     = rw;
    i_wb_sel        = sel;
    i_alu_result    = alu;
    i_imm           = imm;
    i_load_data     = $urandom;
    i_unaligned_pc  = 1'b0;
    i_unaligned_mem = 1'b0;
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'b0010011};
  endfunction

  task automatic test_reset();
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b expected 0", o_ready); end
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_ready, o_trace_valid, o_trace_level, o_halted, o_wb_reg_write} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b tv=%b lvl=%0d halt=%b we=%b expected 1 0 0 0 0",
               o_ready, o_trace_valid, o_trace_level, o_halted, o_wb_reg_write);
    end
    checks++;
    if ({o_instret, o_trace_pc, o_trace_inst, o_trace_rd} !== '0) begin
      failures++;
      $display("FAIL reset_counters: got instret=%0d pc=%h inst=%h rd=%0d expected 0",
               o_instret, o_trace_pc, o_trace_inst, o_trace_rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    i_trace_ready = 1'b1;
    set_inst(addi(5'd1, 12'd5), 32'h0, 5'd1, 1'b1, 3'd0, 32'd5, 32'd5);
    tick();
    set_inst(32'h1234_5137, 32'h4, 5'd2, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h1234_5000);
    @(negedge i_clk);
    checks++;
    if ({o_wb_reg_write, o_wb_rd, o_wb_rd_data} !== {1'b1, 5'd1, 32'd5}) begin
      failures++;
      $display("FAIL b2b_write_x1: got we=%b x%0d=%h expected x1=5", o_wb_reg_write, o_wb_rd, o_wb_rd_data);
    end
    tick();
    i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_wb_reg_write, o_wb_rd, o_wb_rd_data} !== {1'b1, 5'd2, 32'h1234_5000}) begin
      failures++;
      $display("FAIL b2b_write_x2: got we=%b x%0d=%h expected x2=12345000", o_wb_reg_write, o_wb_rd, o_wb_rd_data);
    end
    checks++;
    if ({o_trace_valid, o_trace_pc, o_trace_rd} !== {1'b1, 32'h0, 5'd1}) begin
      failures++;
      $display("FAIL b2b_trace1: got v=%b pc=%h rd=%0d expected 1 0 1", o_trace_valid, o_trace_pc, o_trace_rd);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_wb_reg_write, o_instret, o_trace_pc, o_trace_rd_wdata} !== {1'b0, 64'd2, 32'h4, 32'h1234_5000}) begin
      failures++;
      $display("FAIL b2b_final: got we=%b instret=%0d pc=%h wd=%h expected 0 2 4 12345000",
               o_wb_reg_write, o_instret, o_trace_pc, o_trace_rd_wdata);
    end
    tick();
  endtask

  task automatic test_auipc();
    logic [31:0] pcs [2]  = '{32'h0000_0100, 32'hFFFF_F000};
    logic [31:0] imms [2] = '{32'h0000_2000, 32'h0000_1000};
    logic [31:0] exps [2] = '{32'h0000_2100, 32'h0000_0000};
    i_trace_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_inst(32'h0000_2097, pcs[k], 5'd1, 1'b1, 3'd4, 32'h0, imms[k]);
      tick();
      i_valid = 1'b0;
      @(negedge i_clk);
      checks++;
      if ({o_wb_reg_write, o_wb_rd_data} !== {1'b1, exps[k]}) begin
        failures++;
        $display("FAIL auipc_%0d: got we=%b data=%h expected we=1 data=%h", k, o_wb_reg_write, o_wb_rd_data, exps[k]);
      end
      tick();
    end
    tick();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    do_reset();
    i_trace_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_inst(addi(5'(acc + 1), 12'(100 + acc)), 32'(acc * 4), 5'(acc + 1), 1'b1, 3'd0,
               32'(100 + acc), 32'(100 + acc));
      @(negedge i_clk);
      if (o_ready) acc++;
      tick();
    end
    @(negedge i_clk);
    checks++;
    if (acc != 5) begin failures++; $display("FAIL bp_accepts: got %0d expected 5", acc); end
    checks++;
    if ({o_ready, o_wb_reg_write, o_trace_level, o_instret} !== {1'b0, 1'b0, 3'd4, 64'd4}) begin
      failures++;
      $display("FAIL bp_stalled: got rdy=%b we=%b lvl=%0d instret=%0d expected 0 0 4 4",
               o_ready, o_wb_reg_write, o_trace_level, o_instret);
    end
    tick();
    i_trace_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_wb_reg_write, o_wb_rd, o_wb_rd_data, o_ready} !== {1'b1, 5'd5, 32'd104, 1'b1}) begin
      failures++;
      $display("FAIL bp_pop_retire: got we=%b x%0d=%0d rdy=%b expected x5=104 rdy=1",
               o_wb_reg_write, o_wb_rd, o_wb_rd_data, o_ready);
    end
    tick();
    i_trace_ready = 1'b0;
    i_valid       = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_trace_level, o_instret} !== {3'd4, 64'd5}) begin
      failures++;
      $display("FAIL bp_level_kept: got lvl=%0d instret=%0d expected 4 5", o_trace_level, o_instret);
    end
    tick();
    i_trace_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    @(negedge i_clk);
    checks++;
    if ({o_trace_level, o_instret, o_trace_valid} !== {3'd0, 64'd6, 1'b0}) begin
      failures++;
      $display("FAIL bp_drain: got lvl=%0d instret=%0d v=%b expected 0 6 0", o_trace_level, o_instret, o_trace_valid);
    end
    tick();
  endtask

  task automatic test_store_x0();
    do_reset();
    i_trace_ready = 1'b1;
    set_inst(32'h0020_A023, 32'h8, 5'd5, 1'b0, 3'd0, 32'h55, 32'h0);
    tick();
    i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_wb_reg_write !== 1'b0) begin failures++; $display("FAIL store_no_write: got %b expected 0", o_wb_reg_write); end
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_trace_valid, o_trace_rd, o_trace_rd_wdata} !== {1'b1, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL store_trace: got v=%b rd=%0d wd=%h expected 1 0 0", o_trace_valid, o_trace_rd, o_trace_rd_wdata);
    end
    tick();
    set_inst(addi(5'd0, 12'd7), 32'hC, 5'd0, 1'b1, 3'd0, 32'd7, 32'd7);
    tick();
    i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_wb_reg_write !== 1'b0) begin failures++; $display("FAIL x0_no_write: got %b expected 0", o_wb_reg_write); end
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_trace_valid, o_trace_rd, o_trace_rd_wdata, o_trace_pc} !== {1'b1, 5'd0, 32'd0, 32'hC}) begin
      failures++;
      $display("FAIL x0_trace: got v=%b rd=%0d wd=%h pc=%h expected 1 0 0 c",
               o_trace_valid, o_trace_rd, o_trace_rd_wdata, o_trace_pc);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    i_trace_ready = 1'b0;
    set_inst(addi(5'd1, 12'd1), 32'h0, 5'd1, 1'b1, 3'd0, 32'd1, 32'd1);
    tick();
    set_inst(addi(5'd2, 12'd2), 32'h4, 5'd2, 1'b1, 3'd0, 32'd2, 32'd2);
    tick();
    set_inst(32'h0000_007F, 32'h8, 5'd3, 1'b1, 3'd0, 32'd3, 32'd3);
    tick();
    set_inst(addi(5'd4, 12'd4), 32'hC, 5'd4, 1'b1, 3'd0, 32'd4, 32'd4);
    @(negedge i_clk);
    checks++;
    if ({o_wb_reg_write, o_ready, o_halted} !== 3'b000) begin
      failures++;
      $display("FAIL ill_retire: got we=%b rdy=%b halt=%b expected 0 0 0", o_wb_reg_write, o_ready, o_halted);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_halted, o_ready, o_trace_level} !== {1'b1, 1'b0, 3'd3}) begin
      failures++;
      $display("FAIL ill_halted: got halt=%b rdy=%b lvl=%0d expected 1 0 3", o_halted, o_ready, o_trace_level);
    end
    tick();
    i_trace_ready = 1'b1;
    tick();
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_trace_valid, o_trace_trap, o_trace_halt, o_trace_rd, o_trace_inst} !== {3'b111, 5'd0, 32'h7F}) begin
      failures++;
      $display("FAIL ill_trace: got v=%b trap=%b halt=%b rd=%0d inst=%h expected 1 1 1 0 7f",
               o_trace_valid, o_trace_trap, o_trace_halt, o_trace_rd, o_trace_inst);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_trace_level, o_halted, o_ready, o_instret} !== {3'd0, 1'b1, 1'b0, 64'd3}) begin
      failures++;
      $display("FAIL ill_drained: got lvl=%0d halt=%b rdy=%b instret=%0d expected 0 1 0 3",
               o_trace_level, o_halted, o_ready, o_instret);
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_ebreak_reset();
    do_reset();
    i_trace_ready = 1'b1;
    set_inst(32'h0010_0073, 32'h40, 5'd0, 1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    i_valid = 1'b0;
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_halted, o_trace_valid, o_trace_halt, o_trace_trap} !== 4'b1110) begin
      failures++;
      $display("FAIL ebreak: got halted=%b v=%b halt=%b trap=%b expected 1 1 1 0",
               o_halted, o_trace_valid, o_trace_halt, o_trace_trap);
    end
    tick();
    do_reset();
    i_trace_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      set_inst(addi(5'(c + 1), 12'(c)), 32'(c * 4), 5'(c + 1), 1'b1, 3'd0, 32'(c), 32'(c));
      tick();
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_ready, o_trace_level} !== {1'b0, 3'd4}) begin
      failures++;
      $display("FAIL rst_mid_stall: got rdy=%b lvl=%0d expected 0 4", o_ready, o_trace_level);
    end
    tick();
    i_rst   = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_trace_level, o_instret, o_halted, o_ready, o_trace_valid, o_wb_reg_write} !==
        {3'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_cleared: got lvl=%0d instret=%0d halt=%b rdy=%b v=%b we=%b expected 0 0 0 1 0 0",
               o_trace_level, o_instret, o_halted, o_ready, o_trace_valid, o_wb_reg_write);
    end
    tick();
  endtask

  task automatic test_random();
    int k;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      i_rst           = (o_halted || $urandom_range(0, 149) == 0);
      i_valid         = ($urandom_range(0, 9) < 7);
      i_trace_ready   = ($urandom_range(0, 9) < 6);
      k               = $urandom_range(0, 99);
      i_inst          = $urandom;
      if (k < 95)       i_inst[6:0] = legal_ops[k % 10];
      else if (k >= 98) i_inst = 32'h0010_0073;
      i_pc            = $urandom;
      i_next_pc       = $urandom;
      i_pc_plus_4     = i_pc + 32'd4;
      i_rd            = 5'($urandom);
      i_reg_write     = 1'($urandom);
      i_wb_sel        = 3'($urandom);
      i_alu_result    = $urandom;
      i_load_data     = $urandom;
      i_imm           = $urandom;
      i_unaligned_pc  = ($urandom_range(0, 99) == 0);
      i_unaligned_mem = ($urandom_range(0, 99) == 0);
      tick();
    end
    i_rst   = 1'b0;
    i_valid = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_trace_ready = 1'b0;
    i_inst = '0; i_pc = '0; i_next_pc = '0; i_rd = '0; i_reg_write = 1'b0; i_wb_sel = '0;
    i_alu_result = '0; i_load_data = '0; i_pc_plus_4 = '0; i_imm = '0;
    i_unaligned_pc = 1'b0; i_unaligned_mem = 1'b0;
    mon_en = 1;
    tick();
    test_reset();
    test_back_to_back();
    test_auipc();
    test_backpressure();
    test_store_x0();
    test_illegal();
    test_ebreak_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_retire_unit.md
# wb_retire_unit

Parametrised write-back and retire stage for the RV32I pipeline. Registers one MEM-stage instruction at a time behind a valid/ready handshake, selects and writes register-file data, and detects traps. Pushes one trace record per retired instruction into a TRACE_DEPTH-entry FIFO drained by the verification consumer; back-pressures MEM when that FIFO is full. Latches a halt state on EBREAK or trap and counts retired instructions.

## Interface
- XLEN, 32, datapath width for data, PC and instruction fields.
- TRACE_DEPTH, 4, trace FIFO entries; power of two, ≥2.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset: synchronous, active-high.
- i_valid  in  1  MEM stage presents an instruction.
- o_ready  out  1  stage accepts the instruction this cycle.
- i_inst, i_pc, i_next_pc  in  XLEN each  instruction word, its PC, architectural next PC.
- i_rd  in  5  destination register.
- i_reg_write  in  1  instruction writes rd.
- i_wb_sel  in  3  write-back source: 0 ALU, 1 LOAD, 2 LINK, 3 IMM, 4 PC+IMM; 5–7 treated as ALU.
- i_alu_result, i_load_data, i_pc_plus_4, i_imm  in  XLEN each  candidate write-back operands.
- i_unaligned_pc, i_unaligned_mem  in  1 each  trap flags from earlier stages.
- o_wb_rd  out  5, o_wb_rd_data  out  XLEN, o_wb_reg_write  out  1  register-file write port.
- o_trace_valid  out  1, i_trace_ready  in  1  trace FIFO head handshake.
- o_trace_pc, o_trace_next_pc, o_trace_inst, o_trace_rd_wdata  out  XLEN each; o_trace_rd  out  5; o_trace_trap, o_trace_halt  out  1 each  head record fields.
- o_trace_level  out  $clog2(TRACE_DEPTH)+1  FIFO occupancy.
- o_halted  out  1  halt state latched.
- o_instret  out  64  retired-instruction count.

## Operation
- Stage register R: loads all inputs on accept (i_valid && o_ready) and sets r_valid. Clears r_valid on a retire with no simultaneous accept.
- Retire: r_valid && (fifo_count < TRACE_DEPTH || pop), where pop = o_trace_valid && i_trace_ready. A retire pushes one FIFO record and increments o_instret (wraps at 2^64).
- o_ready = !i_rst && !halted && (!r_valid || retire) && !(retire && r_halt). Stalled R holds its contents unchanged.
- rd data: LOAD→load_data; LINK→pc_plus_4; IMM→imm; PC+IMM→pc+imm, mod 2^XLEN; otherwise alu_result.
- Trap: illegal = opcode[6:0] not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011}. trap = illegal | unaligned_pc | unaligned_mem.
- Halt: r_halt = trap | (inst == 32'h00100073).
- o_wb_reg_write = retire && reg_write && rd != 0 && !trap. o_wb_rd and o_wb_rd_data are driven from R.
- Trace record contents:
  - pc, next_pc, inst from R.
  - rd = (reg_write && !trap) ? rd : 0.
  - rd_wdata = computed rd data if record rd ≠ 0, else 0.
  - trap and halt flags from R.
- Halt FSM, two states:
  - RUN → HALTED on a retire with r_halt.
  - HALTED: o_halted=1, o_ready=0, no further accepts. Exit only via reset.
  - The FIFO keeps draining in HALTED.

## Timing
- Reset values: R and FIFO cleared, FSM RUN, o_instret=0, o_halted=0, o_trace_valid=0, o_trace_level=0, o_wb_reg_write=0, all trace fields 0. o_ready=0 while i_rst is high; o_ready=1 the first cycle after.
- Accept to register-file write: 1 cycle when the FIFO has space. Each extra full-FIFO cycle adds 1. Exactly one write per instruction.
- Accept to trace visible at head: 2 cycles with an empty FIFO. The FIFO write is registered: a record pushed in cycle N is visible at cycle N+1.
- Full FIFO with pop in the same cycle: retire and push both proceed; level is unchanged.
- Empty FIFO: o_trace_valid=0, head fields hold 0.
- Pointers wrap modulo TRACE_DEPTH.
- Reset mid-operation: all in-flight R and FIFO contents are discarded and the halt state is cleared.

## Test plan
- Back-to-back ADDI x1 (alu_result=5) then LUI x2 (imm=0x12345000), i_trace_ready=1 → writes x1=5 then x2=0x12345000 on consecutive cycles; two records, o_instret=2.
- AUIPC: pc=0x100, imm=0x2000, wb_sel=4 → rd_data=0x2100. Same with pc=0xFFFFF000, imm=0x1000 → 0x00000000 (wrap).
- i_trace_ready=0 with TRACE_DEPTH=4, stream 6 instructions → 4 retire; o_ready=0 after the 5th is accepted; no register-file write for the 5th while stalled. Raise ready for 1 cycle → the 5th retires same cycle as the pop; level stays 4.
- Store with i_reg_write=0 → o_trace_rd=0, o_trace_rd_wdata=0. Instruction to rd=x0 with reg_write=1 → no register-file write.
- Opcode 0x7F with reg_write=1 → o_wb_reg_write=0, trace trap=1 and halt=1, o_halted next cycle, o_ready stays 0; queued records still drain.
- EBREAK 0x00100073 → halt=1, trap=0. Assert i_rst mid-stall → level=0, o_instret=0, o_halted=0, o_ready=1 the cycle after reset deasserts.
